// File: rtl/cpu4_seq_if.sv
// Issue/complete handshake between the program sequencer and the 4-bit datapath.
interface cpu4_seq_if;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_opcode;
  logic [3:0] issue_addr;
  logic [3:0] issue_data;
  logic       exec_done;

  // Sequencer side: presents instructions, receives accept and completion.
  modport master (
    output issue_valid,
    output issue_opcode,
    output issue_addr,
    output issue_data,
    input  issue_ready,
    input  exec_done
  );

  // Datapath side.
  modport slave (
    input  issue_valid,
    input  issue_opcode,
    input  issue_addr,
    input  issue_data,
    output issue_ready,
    output exec_done
  );
endinterface

// File: rtl/cpu4_program_sequencer.sv
// Program sequencer for the 4-bit accumulator CPU: holds a small program, issues
// datapath opcodes over a valid/ready handshake and waits for completion pulses.
// JMP and HALT are handled locally; unassigned opcodes act as NOPs.
module cpu4_program_sequencer #(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned PC_W       = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [11:0]     prog_word,
  input  logic            start,
  input  logic            stop,
  cpu4_seq_if.master      bus,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StHalt
  } state_e;

  localparam logic [3:0] OpJmp  = 4'b1110;
  localparam logic [3:0] OpHalt = 4'b1111;
  // Last counter value tolerated in WAIT; one more cycle without completion faults.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            fault_q, fault_d;
  logic [3:0]      op_q, op_d;
  logic [3:0]      addr_q, addr_d;
  logic [3:0]      data_q, data_d;

  logic [11:0]     mem [PROG_DEPTH];
  logic [11:0]     word;
  logic [3:0]      w_op, w_addr, w_data;
  logic            is_dp;

  assign word   = mem[pc_q];
  assign w_op   = word[11:8];
  assign w_addr = word[7:4];
  assign w_data = word[3:0];

  // Classify the fetched opcode: datapath ops are issued, everything else is local.
  always_comb begin
    is_dp = 1'b0;
    unique case (w_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010: is_dp = 1'b1;
      default:                   is_dp = 1'b0;
    endcase
  end

  // Program store; not reset, and writes are dropped while a program runs.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_word;
    end
  end

  // State, PC, timeout counter and latched issue fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; stop overrides every other event in every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;

    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StFetch;
            pc_d    = '0;
            fault_d = 1'b0;
          end
        end
        StFetch: begin
          if (w_op == OpHalt) begin
            state_d = StHalt;
          end else if (w_op == OpJmp) begin
            pc_d = w_addr[PC_W-1:0];
          end else if (is_dp) begin
            op_d    = w_op;
            addr_d  = w_addr;
            data_d  = w_data;
            state_d = StIssue;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        StIssue: begin
          // exec_done here is ignored; completion is only taken from WAIT.
          if (bus.issue_ready) begin
            state_d = StWait;
            cnt_d   = '0;
          end
        end
        StWait: begin
          if (bus.exec_done) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = StFetch;
          end else if (cnt_q == TimeoutLast) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StHalt: begin
          if (start) begin
            state_d = StFetch;
            pc_d    = '0;
            fault_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    bus.issue_valid  = (state_q == StIssue);
    bus.issue_opcode = op_q;
    bus.issue_addr   = addr_q;
    bus.issue_data   = data_q;
    busy             = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWait);
    halted           = (state_q == StHalt);
    fault            = fault_q;
    pc               = pc_q;
  end

endmodule

// File: tb/tb_cpu4_program_sequencer.sv
// Directed bench for cpu4_program_sequencer (TIMEOUT set to 3).
module tb_cpu4_program_sequencer;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_word;
  logic        start;
  logic        stop;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [3:0]  pc;

  int n_cmp;
  int n_err;

  cpu4_seq_if u_if ();

  cpu4_program_sequencer #(
    .PROG_DEPTH (16),
    .PC_W       (4),
    .TIMEOUT    (3)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_word (prog_word),
    .start     (start),
    .stop      (stop),
    .bus       (u_if),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [11:0] w);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_word = w;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if ({busy, halted, fault} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags: got %b want 000", {busy, halted, fault}); end
    n_cmp++; if (pc !== 4'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", pc); end
    n_cmp++; if ({u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data} !== 13'd0)
      begin n_err++; $display("FAIL reset_issue: got %h want 0",
        {u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_program();
    write_word(4'd0, 12'h330);
    write_word(4'd1, 12'h005);
    write_word(4'd2, 12'hF00);
    u_if.issue_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if ({busy, u_if.issue_valid, pc} !== 6'b10_0000) begin n_err++;
      $display("FAIL basic_fetch: got %b want 100000", {busy, u_if.issue_valid, pc}); end
    step();
    n_cmp++; if ({u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data} !== 13'h1330)
      begin n_err++; $display("FAIL basic_issue0: got %h want 1330",
        {u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data}); end
    step();
    n_cmp++; if ({busy, u_if.issue_valid} !== 2'b10) begin n_err++;
      $display("FAIL basic_wait0: got %b want 10", {busy, u_if.issue_valid}); end
    step();
    u_if.exec_done = 1'b1;
    step();
    u_if.exec_done = 1'b0;
    n_cmp++; if (pc !== 4'd1) begin n_err++; $display("FAIL basic_pc1: got %0d want 1", pc); end
    step();
    n_cmp++; if ({u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data} !== 13'h1005)
      begin n_err++; $display("FAIL basic_issue1: got %h want 1005",
        {u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data}); end
    step();
    step();
    u_if.exec_done = 1'b1;
    step();
    u_if.exec_done = 1'b0;
    step();
    n_cmp++; if ({halted, busy, u_if.issue_valid, pc} !== 7'b100_0010) begin n_err++;
      $display("FAIL basic_halt: got %b want 1000010", {halted, busy, u_if.issue_valid, pc}); end
    go_idle();
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_stop: got %b want 0", halted); end
  endtask

  task automatic test_backpressure();
    write_word(4'd0, 12'h1A7);
    write_word(4'd1, 12'hF00);
    u_if.issue_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data} !== 13'h11A7)
        begin n_err++; $display("FAIL bp_hold%0d: got %h want 11a7", i,
          {u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data}); end
      u_if.exec_done = (i == 2);
      step();
      u_if.exec_done = 1'b0;
    end
    n_cmp++; if ({u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data} !== 13'h11A7)
      begin n_err++; $display("FAIL bp_cycle6: got %h want 11a7",
        {u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data}); end
    u_if.issue_ready = 1'b1;
    u_if.exec_done   = 1'b1;
    step();
    u_if.exec_done   = 1'b0;
    n_cmp++; if ({busy, u_if.issue_valid, pc} !== 6'b10_0000) begin n_err++;
      $display("FAIL bp_wait: got %b want 100000", {busy, u_if.issue_valid, pc}); end
    step();
    n_cmp++; if ({busy, pc} !== 5'b1_0000) begin n_err++;
      $display("FAIL bp_done_ignored: got %b want 10000", {busy, pc}); end
    u_if.exec_done = 1'b1;
    step();
    u_if.exec_done = 1'b0;
    step();
    n_cmp++; if ({halted, pc} !== 5'b1_0001) begin n_err++;
      $display("FAIL bp_halt: got %b want 10001", {halted, pc}); end
    go_idle();
  endtask

  task automatic test_jmp();
    logic saw;
    saw = 1'b0;
    write_word(4'd0, 12'hE40);
    write_word(4'd4, 12'hF00);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (halted) break;
      if (u_if.issue_valid) saw = 1'b1;
      step();
    end
    n_cmp++; if ({halted, pc} !== 5'b1_0100) begin n_err++;
      $display("FAIL jmp_halt: got %b want 10100", {halted, pc}); end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL jmp_no_issue: got %b want 0", saw); end
    go_idle();
  endtask

  task automatic test_timeout();
    write_word(4'd0, 12'h212);
    write_word(4'd1, 12'hF00);
    u_if.issue_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_cmp++; if ({busy, halted, fault} !== 3'b100) begin n_err++;
      $display("FAIL to_wait0: got %b want 100", {busy, halted, fault}); end
    step();
    step();
    n_cmp++; if ({busy, halted, fault} !== 3'b100) begin n_err++;
      $display("FAIL to_wait2: got %b want 100", {busy, halted, fault}); end
    step();
    n_cmp++; if ({busy, halted, fault, pc} !== 7'b011_0000) begin n_err++;
      $display("FAIL to_fault: got %b want 0110000", {busy, halted, fault, pc}); end
    step();
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", fault); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if ({busy, halted, fault, pc} !== 7'b100_0000) begin n_err++;
      $display("FAIL to_restart: got %b want 1000000", {busy, halted, fault, pc}); end
    go_idle();
  endtask

  task automatic test_stop();
    write_word(4'd0, 12'h5C3);
    write_word(4'd1, 12'hF00);
    u_if.issue_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stop_in_wait: got %b want 1", busy); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    u_if.exec_done = 1'b1;
    n_cmp++; if ({busy, halted, u_if.issue_valid, pc} !== 7'b000_0000) begin n_err++;
      $display("FAIL stop_idle: got %b want 0000000", {busy, halted, u_if.issue_valid, pc}); end
    step();
    u_if.exec_done = 1'b0;
    n_cmp++; if ({busy, halted, pc} !== 6'b00_0000) begin n_err++;
      $display("FAIL stop_late_done: got %b want 000000", {busy, halted, pc}); end
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_vs_start: got %b want 0", busy); end
  endtask

  task automatic test_write_while_busy();
    write_word(4'd0, 12'h5F1);
    write_word(4'd1, 12'hF00);
    u_if.issue_ready = 1'b1;
    start = 1'b1;
    step();
    start     = 1'b0;
    prog_we   = 1'b1;
    prog_addr = 4'd1;
    prog_word = 12'h7AB;
    step();
    prog_we   = 1'b0;
    n_cmp++; if ({u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data} !== 13'h15F1)
      begin n_err++; $display("FAIL wb_issue: got %h want 15f1",
        {u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data}); end
    step();
    step();
    u_if.exec_done = 1'b1;
    step();
    u_if.exec_done = 1'b0;
    step();
    n_cmp++; if ({halted, u_if.issue_valid, pc} !== 6'b10_0001) begin n_err++;
      $display("FAIL wb_dropped: got %b want 100001", {halted, u_if.issue_valid, pc}); end
    go_idle();
  endtask

  task automatic test_wrap();
    logic saw;
    logic [3:0] op;
    saw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       op = 4'h4;
        1:       op = 4'hB;
        2:       op = 4'hC;
        default: op = 4'hD;
      endcase
      write_word(4'(i), {op, 8'h00});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      if (u_if.issue_valid) saw = 1'b1;
      step();
    end
    n_cmp++; if (pc !== 4'd15) begin n_err++; $display("FAIL wrap_pc15: got %0d want 15", pc); end
    step();
    n_cmp++; if ({busy, pc} !== 5'b1_0000) begin n_err++;
      $display("FAIL wrap_pc0: got %b want 10000", {busy, pc}); end
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if ({busy, saw, pc} !== 6'b00_0001) begin n_err++;
      $display("FAIL wrap_stop: got %b want 000001", {busy, saw, pc}); end
    write_word(4'd0, 12'hF00);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++; if ({halted, pc} !== 5'b1_0000) begin n_err++;
      $display("FAIL wrap_halt0: got %b want 10000", {halted, pc}); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    write_word(4'd0, 12'h9A5);
    u_if.issue_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++; if ({u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data} !== 13'h19A5)
      begin n_err++; $display("FAIL rm_issue: got %h want 19a5",
        {u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({u_if.issue_valid, u_if.issue_opcode, u_if.issue_addr, u_if.issue_data,
                  busy, halted, fault, pc} !== 20'd0) begin n_err++;
      $display("FAIL rm_async: got %h want 0", {u_if.issue_valid, u_if.issue_opcode,
        u_if.issue_addr, u_if.issue_data, busy, halted, fault, pc}); end
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_cmp            = 0;
    n_err            = 0;
    rst_n            = 1'b0;
    prog_we          = 1'b0;
    prog_addr        = '0;
    prog_word        = '0;
    start            = 1'b0;
    stop             = 1'b0;
    u_if.issue_ready = 1'b0;
    u_if.exec_done   = 1'b0;
    test_reset();
    test_basic_program();
    test_backpressure();
    test_jmp();
    test_timeout();
    test_stop();
    test_write_while_busy();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu4_program_sequencer.md
Name: cpu4_program_sequencer

Overview:
Instruction sequencer placed in front of the 4-bit accumulator CPU datapath. It holds a small program (opcode/address/data triplets) written over a load port, then steps through it. Each instruction is issued to the datapath over a valid/ready handshake, and the sequencer waits for the datapath's completion pulse before advancing. Sequencer-only opcodes JMP and HALT are interpreted locally and never issued.

Parameters:
PROG_DEPTH, 16, number of program words; power of two, 2..16
PC_W, 4, program-counter width = log2(PROG_DEPTH)
TIMEOUT, 15, maximum cycles in WAIT before fault; 1..255

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
prog_we  in  1  program write strobe; accepted only when busy=0
prog_addr  in  PC_W  program write address
prog_word  in  12  {opcode[11:8], addr[7:4], data[3:0]}
start  in  1  begin execution at PC 0; ignored while busy=1
stop  in  1  abort execution, return to IDLE
issue_valid  out  1  instruction presented to datapath
issue_ready  in  1  datapath accepts instruction
issue_opcode  out  4  datapath opcode
issue_addr  out  4  memory address field
issue_data  out  4  immediate data field
exec_done  in  1  one-cycle pulse: datapath finished the issued instruction
busy  out  1  high in FETCH/ISSUE/WAIT
halted  out  1  high in HALT state
fault  out  1  sticky; set on WAIT timeout, cleared by start or reset
pc  out  PC_W  current program counter

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pc=0, issue_valid=0, issue_* fields=0, busy=0, halted=0, fault=0, timeout counter=0. Program memory contents are not reset; the bench must write before start.
- Program memory: PROG_DEPTH x 12 registers, written synchronously when prog_we=1 and busy=0. Writes while busy=1 are dropped.
- Opcodes are passed through unchanged: 0000 ADD, 0001 SUB, 0010 STORE, 0011 LOAD, 0101 AND, 0110 OR, 0111 XOR, 1000 NOT, 1001 SHL, 1010 SHR. 1110 JMP (target = addr field) and 1111 HALT are local. All other opcodes (0100, 1011-1101) are NOP: pc advances and nothing is issued.
- States:
  - IDLE: start=1 -> FETCH with pc=0, fault cleared.
  - FETCH (1 cycle): read word[pc]. HALT -> HALT. JMP -> pc=addr[PC_W-1:0], stay in FETCH. NOP -> pc+1, stay in FETCH. Otherwise latch the fields onto issue_* and go to ISSUE.
  - ISSUE: issue_valid=1, with fields held stable until the handshake. On issue_valid & issue_ready -> WAIT, issue_valid low next cycle.
  - WAIT: counter increments each cycle. On exec_done -> pc+1, FETCH. If the counter reaches TIMEOUT without exec_done -> fault=1, HALT.
  - HALT: halted=1. start -> FETCH at pc=0. stop -> IDLE.
- PC wrap: pc+1 from PROG_DEPTH-1 wraps to 0, with no flag.
- Latency: a datapath opcode at pc yields issue_valid 1 cycle after entering FETCH. exec_done in cycle N gives FETCH in N+1.
- stop has priority over every other event in every state. It goes to IDLE next cycle, drops issue_valid, and leaves pc unchanged. A datapath operation in flight is abandoned, and a late exec_done is ignored.
- exec_done outside WAIT is ignored. exec_done in the same cycle as the ISSUE handshake is ignored; completion is only accepted from WAIT.
- start and stop in the same cycle: stop wins.
- A JMP-to-self loop stays in FETCH indefinitely; this is legal and exited only by stop or reset.
- Reset asserted mid-operation: immediate return to the reset values above.

Test Plan:
- Load {0011,0x3,0}, {0000,0,0x5}, {1111,0,0}; start; ready=1, exec_done 2 cycles after each issue -> two issues (opcodes 0011 then 0000, data 5), then halted=1 with pc=2.
- Hold issue_ready=0 for 5 cycles during ISSUE -> issue_valid stays 1 with fields unchanged; handshake on cycle 6; WAIT entered the following cycle.
- Word0={1110,0x4,0}, word4={1111,0,0}; start -> no issue_valid ever asserted; halted=1 with pc=4.
- TIMEOUT=3, exec_done never pulsed -> fault=1 and halted=1 exactly 3 cycles after entering WAIT; a subsequent start clears fault.
- Assert stop while in WAIT, then pulse exec_done next cycle -> IDLE with busy=0, pc unchanged, no FETCH.
- prog_we to address 1 while busy=1 -> word 1 unchanged when read back by a later run; program of 16 NOPs plus HALT at 0 -> pc wraps 15->0 and halts.
